reaction_display: RTL

// - Consumer of the reaction timer's o_state/o_ticks outputs. Drives a 4-digit multiplexed 7-segment display.
// - On entry to VALID: converts ticks to whole ms (sequential divide), then to BCD (sequential double-dabble), latches the result.
// - Other states show fixed glyphs.
// - Sits beside the reaction timer at board top level, same 50 MHz domain.

---
 rtl/reaction_display.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/reaction_display.sv
// rtl/reaction_display.sv - reaction-time result converter and 4-digit multiplexed 7-segment driver.
// Optional macro REACTION_DISPLAY_LZB_EN blanks leading zeros of the VALID result.
module reaction_display #(
   parameter int unsigned TICKS_PER_MS = 50000,
   parameter int unsigned SCAN_DIV     = 50000
) (
   input  logic        i_clk_50m,
   input  logic        i_rst,
   input  logic [2:0]  i_state,
   input  logic [27:0] i_ticks,
   output logic [7:0]  o_seg_n,
   output logic [3:0]  o_dig_n,
   output logic [15:0] o_bcd,
   output logic        o_busy
);

   localparam logic [2:0] ST_IDLE  = 3'b000;
   localparam logic [2:0] ST_ARMED = 3'b001;
   localparam logic [2:0] ST_LIT   = 3'b010;
   localparam logic [2:0] ST_LATE  = 3'b011;
   localparam logic [2:0] ST_EARLY = 3'b110;
   localparam logic [2:0] ST_VALID = 3'b100;

   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
   localparam logic [27:0]   DIVISOR   = 28'(TICKS_PER_MS);

   typedef enum logic [1:0] {C_IDLE, C_DIV, C_BCD, C_DONE} conv_e;

   function automatic logic [7:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 8'hC0;
         4'd1:    seg7 = 8'hF9;
         4'd2:    seg7 = 8'hA4;
         4'd3:    seg7 = 8'hB0;
         4'd4:    seg7 = 8'h99;
         4'd5:    seg7 = 8'h92;
         4'd6:    seg7 = 8'h82;
         4'd7:    seg7 = 8'hF8;
         4'd8:    seg7 = 8'h80;
         4'd9:    seg7 = 8'h90;
         default: seg7 = 8'hFF;
      endcase
   endfunction

   function automatic logic [3:0] add3(input logic [3:0] n);
      add3 = (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   conv_e        state_q, state_d;
   logic [4:0]   cnt_q, cnt_d;
   logic [27:0]  quo_q, quo_d;
   logic [27:0]  rem_q, rem_d;
   logic [13:0]  bin_q, bin_d;
   logic [15:0]  work_q, work_d;
   logic [15:0]  bcd_q, bcd_d;
   logic         busy_q, busy_d;
   logic [2:0]   prev_q;
   logic         rdy_q;
   logic [SW-1:0] scan_q, scan_d;
   logic [1:0]   dig_q, dig_d;
   logic [7:0]   seg_q, seg_d;
   logic [3:0]   digen_q, digen_d;

   logic         entry;
   logic [28:0]  shifted;
   logic [27:0]  diff;
   logic         ge;
   logic [13:0]  sat;
   logic [15:0]  adj;
   logic         scan_wrap;
   logic [3:0]   nib;
   logic         lead_blank;
   logic         unused_adj_msb;

   // rdy_q holds off detection after reset until the state has been seen outside VALID
   assign entry   = (i_state == ST_VALID) && (prev_q != ST_VALID) && rdy_q;
   assign shifted = {rem_q, quo_q[27]};
   assign ge      = shifted >= {1'b0, DIVISOR};
   assign diff    = shifted[27:0] - DIVISOR;
   assign sat     = (quo_q > 28'd9999) ? 14'd9999 : quo_q[13:0];
   assign adj     = {add3(work_q[15:12]), add3(work_q[11:8]), add3(work_q[7:4]), add3(work_q[3:0])};
   assign unused_adj_msb = adj[15];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      bin_d   = bin_q;
      work_d  = work_q;
      bcd_d   = bcd_q;
      busy_d  = busy_q;
      if (entry) begin
         quo_d   = i_ticks;
         rem_d   = '0;
         cnt_d   = '0;
         busy_d  = 1'b1;
         state_d = C_DIV;
      end else begin
         case (state_q)
            C_DIV: begin
               quo_d = {quo_q[26:0], ge};
               rem_d = ge ? diff : shifted[27:0];
               if (cnt_q == 5'd27) begin
                  cnt_d   = '0;
                  state_d = C_BCD;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
            // first C_BCD clock loads the saturated quotient, then 14 add-3/shift steps
            C_BCD: begin
               if (cnt_q == 5'd0) begin
                  bin_d  = sat;
                  work_d = '0;
                  cnt_d  = 5'd1;
               end else begin
                  work_d = {adj[14:0], bin_q[13]};
                  bin_d  = {bin_q[12:0], 1'b0};
                  if (cnt_q == 5'd14) state_d = C_DONE;
                  else                cnt_d   = cnt_q + 5'd1;
               end
            end
            C_DONE: begin
               bcd_d   = work_q;
               busy_d  = 1'b0;
               state_d = C_IDLE;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      scan_wrap = (scan_q == SCAN_LAST);
      scan_d    = scan_wrap ? '0 : scan_q + SW'(1);
      dig_d     = scan_wrap ? dig_q + 2'd1 : dig_q;
      nib       = bcd_q[{dig_d, 2'b00} +: 4];
`ifdef REACTION_DISPLAY_LZB_EN
      lead_blank = ((dig_d == 2'd3) && (bcd_q[15:12] == 4'd0)) ||
                   ((dig_d == 2'd2) && (bcd_q[15:8]  == 8'd0)) ||
                   ((dig_d == 2'd1) && (bcd_q[15:4]  == 12'd0));
`else
      lead_blank = 1'b0;
`endif
      seg_d = 8'hFF;
      case (i_state)
         ST_IDLE:  seg_d = 8'hBF;
         ST_ARMED: seg_d = 8'hFF;
         ST_LIT:   seg_d = 8'h80;
         ST_LATE: begin
            case (dig_d)
               2'd3:    seg_d = 8'hC7;
               2'd2:    seg_d = 8'h88;
               2'd1:    seg_d = 8'h87;
               default: seg_d = 8'h86;
            endcase
         end
         ST_EARLY: begin
            case (dig_d)
               2'd3:    seg_d = 8'h86;
               2'd2:    seg_d = 8'hAF;
               2'd1:    seg_d = 8'hAF;
               default: seg_d = 8'hFF;
            endcase
         end
         ST_VALID: seg_d = lead_blank ? 8'hFF : seg7(nib);
         default:  seg_d = 8'hFF;
      endcase
      digen_d = ~(4'b0001 << dig_d);
   end

   always_ff @(posedge i_clk_50m or posedge i_rst) begin
      if (i_rst) begin
         state_q <= C_IDLE;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         bin_q   <= '0;
         work_q  <= '0;
         bcd_q   <= '0;
         busy_q  <= 1'b0;
         prev_q  <= ST_IDLE;
         rdy_q   <= 1'b0;
         scan_q  <= '0;
         dig_q   <= '0;
         seg_q   <= 8'hFF;
         digen_q <= 4'hF;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         bin_q   <= bin_d;
         work_q  <= work_d;
         bcd_q   <= bcd_d;
         busy_q  <= busy_d;
         prev_q  <= i_state;
         rdy_q   <= rdy_q | (i_state != ST_VALID);
         scan_q  <= scan_d;
         dig_q   <= dig_d;
         seg_q   <= seg_d;
         digen_q <= digen_d;
      end
   end

   assign o_seg_n = seg_q;
   assign o_dig_n = digen_q;
   assign o_bcd   = bcd_q;
   assign o_busy  = busy_q;

endmodule
